// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the byte-lane merge used by
// register-file style slaves.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Sized for the widest AXI data bus; callers zero-extend in and truncate out.
  localparam int MERGE_MAX_WIDTH = 1024;
  localparam int MERGE_MAX_STRB  = MERGE_MAX_WIDTH / 8;

  function automatic logic [MERGE_MAX_WIDTH-1:0] merge_bytes(
    input logic [MERGE_MAX_WIDTH-1:0] old_word,
    input logic [MERGE_MAX_WIDTH-1:0] new_word,
    input logic [MERGE_MAX_STRB-1:0]  strb
  );
    logic [MERGE_MAX_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < MERGE_MAX_STRB; i++) begin
      if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/axi4_lite_read_pipe.sv
// Fixed-latency valid/data/resp shift pipeline for the read channel. The whole
// pipeline freezes while the last stage is valid and not accepted.
module axi4_lite_read_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_resp,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_resp
);

  logic                  valid_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_q  [LATENCY];
  logic [1:0]            resp_q  [LATENCY];
  logic                  stall;

  assign stall = valid_q[LATENCY-1] && !out_ready;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int k = 0; k < LATENCY; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        resp_q[k]  <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      resp_q[0]  <= in_resp;
      for (int k = 1; k < LATENCY; k++) begin
        valid_q[k] <= valid_q[k-1];
        data_q[k]  <= data_q[k-1];
        resp_q[k]  <= resp_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign out_resp  = resp_q[LATENCY-1];

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register-file slave: byte-strobed writes with independent AW/W
// capture, decode errors, and a configurable-latency single-outstanding read.
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [1:0]            BRESP,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [2:0]            ARPROT,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP
);

  localparam int LANE_SHIFT = $clog2(STRB_WIDTH);
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  b_valid;
  logic [1:0]            b_resp;
  logic                  aw_fire, w_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_index;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_merged;

  logic                  ar_busy, ar_fire;
  logic [ADDR_WIDTH-1:0] rd_index;
  logic                  rd_ok;
  logic                  rd_sample_valid;
  logic [DATA_WIDTH-1:0] rd_sample_data;
  logic [1:0]            rd_sample_resp;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  assign AWREADY = !aw_held && !b_valid;
  assign WREADY  = !w_held && !b_valid;
  assign BVALID  = b_valid;
  assign BRESP   = b_resp;

  assign aw_fire  = AWVALID && AWREADY;
  assign w_fire   = WVALID && WREADY;
  assign commit   = aw_held && w_held;
  assign wr_index = aw_addr >> LANE_SHIFT;
  assign wr_ok    = wr_index < ADDR_WIDTH'(DEPTH);
  assign wr_merged = DATA_WIDTH'(merge_bytes(MERGE_MAX_WIDTH'(mem[wr_index[IDX_W-1:0]]),
                                             MERGE_MAX_WIDTH'(w_data),
                                             MERGE_MAX_STRB'(w_strb)));

  // Write capture and response: the commit fires on the edge after both halves
  // are held, which also keeps the readys low until the B handshake.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      b_valid <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_ok ? RESP_OKAY : RESP_DECERR;
      end else if (b_valid && BREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && wr_ok) begin
      mem[wr_index[IDX_W-1:0]] <= wr_merged;
    end
  end

  assign ARREADY  = !ar_busy;
  assign ar_fire  = ARVALID && ARREADY;
  assign rd_index = ARADDR >> LANE_SHIFT;
  assign rd_ok    = rd_index < ADDR_WIDTH'(DEPTH);

  // The array is sampled at the AR edge so a same-edge commit is not seen.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ar_busy         <= 1'b0;
      rd_sample_valid <= 1'b0;
      rd_sample_data  <= '0;
      rd_sample_resp  <= RESP_OKAY;
    end else begin
      rd_sample_valid <= ar_fire;
      rd_sample_data  <= (ar_fire && rd_ok) ? mem[rd_index[IDX_W-1:0]] : '0;
      rd_sample_resp  <= (ar_fire && !rd_ok) ? RESP_DECERR : RESP_OKAY;
      if (ar_fire) begin
        ar_busy <= 1'b1;
      end else if (RVALID && RREADY) begin
        ar_busy <= 1'b0;
      end
    end
  end

  axi4_lite_read_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .LATENCY   (READ_LATENCY)
  ) u_read_pipe (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .in_valid (rd_sample_valid),
    .in_data  (rd_sample_data),
    .in_resp  (rd_sample_resp),
    .out_ready(RREADY),
    .out_valid(RVALID),
    .out_data (RDATA),
    .out_resp (RRESP)
  );

endmodule
